sad2_reduce_min_stage: RTL and testbench

SAD2_REDUCE_MIN_STAGE -- requirements
Module: sad2_reduce_min_stage

---
 rtl/sad2_reduce_min_stage.sv | 192 +++++++++++++++++++
 tb/tb_sad2_reduce_min_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad2_reduce_min_stage.sv
// -----------------------------------------------------------------------------
// sad2_reduce_min_stage
//
// Purpose
//   Final reduction stage of the SAD pipeline. Sixteen absolute differences
//   from stage C are summed in two registered steps (four 34-bit partial sums,
//   then one 36-bit total). The total is saturated to 32 bits. A running
//   minimum search tracks the smallest result, and its window index, since
//   the last Start pulse.
//
// Ports
//   Clk          rising-edge clock, the only clock
//   Reset        asynchronous, active-low reset
//   InValid      D0..D15 carry a SAD operation this cycle
//   D0..D15      sixteen unsigned 32-bit absolute differences
//   RegWriteIn   register-write control travelling with the operation
//   RegDstIn     destination register number travelling with the operation
//   Stall        pipeline hold; freezes every register (Start still applies
//                to the search registers)
//   Start        single-cycle pulse that begins a new minimum search
//   OutValid     SADSum / RegWriteOut / RegDstOut are valid
//   SADSum       saturated sum of the sixteen differences
//   RegWriteOut  stage-2 RegWrite gated by OutValid
//   RegDstOut    stage-2 RegDst
//   MinSAD       smallest SADSum since the last Start (all ones when none)
//   MinIndex     window index of MinSAD
//   WinCount     number of valid results since the last Start (wraps)
//
// Latency: OutValid rises two unstalled cycles after InValid is sampled.
// -----------------------------------------------------------------------------
module sad2_reduce_min_stage #(
  parameter int IDX_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  input  logic [31:0]      D0,
  input  logic [31:0]      D1,
  input  logic [31:0]      D2,
  input  logic [31:0]      D3,
  input  logic [31:0]      D4,
  input  logic [31:0]      D5,
  input  logic [31:0]      D6,
  input  logic [31:0]      D7,
  input  logic [31:0]      D8,
  input  logic [31:0]      D9,
  input  logic [31:0]      D10,
  input  logic [31:0]      D11,
  input  logic [31:0]      D12,
  input  logic [31:0]      D13,
  input  logic [31:0]      D14,
  input  logic [31:0]      D15,
  input  logic             RegWriteIn,
  input  logic [4:0]       RegDstIn,
  input  logic             Stall,
  input  logic             Start,
  output logic             OutValid,
  output logic [31:0]      SADSum,
  output logic             RegWriteOut,
  output logic [4:0]       RegDstOut,
  output logic [31:0]      MinSAD,
  output logic [IDX_W-1:0] MinIndex,
  output logic [IDX_W-1:0] WinCount
);

  localparam logic [31:0] SadMax = 32'hFFFF_FFFF;

  // Four 32-bit operands never exceed 34 bits, so no carry is lost here.
  function automatic logic [33:0] sum4(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c,
                                       input logic [31:0] d);
    return 34'(a) + 34'(b) + 34'(c) + 34'(d);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: partial sums and control copies
  // ---------------------------------------------------------------------------
  logic        s1Valid;
  logic [33:0] s1P0;
  logic [33:0] s1P1;
  logic [33:0] s1P2;
  logic [33:0] s1P3;
  logic        s1RegWrite;
  logic [4:0]  s1RegDst;

  // ---------------------------------------------------------------------------
  // Stage 2: full-width total and control copies
  // ---------------------------------------------------------------------------
  logic        s2Valid;
  logic [35:0] s2Total;
  logic        s2RegWrite;
  logic [4:0]  s2RegDst;

  logic [35:0] total;

  always_comb begin
    total = 36'(s1P0) + 36'(s1P1) + 36'(s1P2) + 36'(s1P3);
  end

  // Data registers load on every unstalled cycle; a bubble carries whatever
  // is on D0..D15 but its valid bit is 0, so nothing downstream uses it.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge value of its source, independent of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1Valid    <= 1'b0;
      s1P0       <= '0;
      s1P1       <= '0;
      s1P2       <= '0;
      s1P3       <= '0;
      s1RegWrite <= 1'b0;
      s1RegDst   <= '0;
      s2Valid    <= 1'b0;
      s2Total    <= '0;
      s2RegWrite <= 1'b0;
      s2RegDst   <= '0;
    end else if (!Stall) begin
      s1Valid    <= InValid;
      s1P0       <= sum4(D0,  D1,  D2,  D3);
      s1P1       <= sum4(D4,  D5,  D6,  D7);
      s1P2       <= sum4(D8,  D9,  D10, D11);
      s1P3       <= sum4(D12, D13, D14, D15);
      s1RegWrite <= RegWriteIn;
      s1RegDst   <= RegDstIn;
      s2Valid    <= s1Valid;
      s2Total    <= total;
      s2RegWrite <= s1RegWrite;
      s2RegDst   <= s1RegDst;
    end
  end

  // Any set bit above bit 31 means the true sum does not fit: clamp.
  always_comb begin
    OutValid    = s2Valid;
    SADSum      = (s2Total[35:32] == 4'd0) ? s2Total[31:0] : SadMax;
    RegWriteOut = s2RegWrite & s2Valid;
    RegDstOut   = s2RegDst;
  end

  // ---------------------------------------------------------------------------
  // Minimum search
  // ---------------------------------------------------------------------------
  // A result is counted only on an unstalled cycle. While stalled, OutValid
  // stays high on the same result, and it is counted on the cycle the stall
  // releases. Start is honoured even under Stall. A result that is not
  // counted in that cycle will be counted after the stall, as index 0.
  logic             countResult;
  logic [31:0]      minNext;
  logic [IDX_W-1:0] idxNext;
  logic [IDX_W-1:0] cntNext;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    countResult = OutValid & ~Stall;
    minNext     = MinSAD;
    idxNext     = MinIndex;
    cntNext     = WinCount;
    if (Start) begin
      idxNext = '0;
      if (countResult) begin
        minNext = SADSum;
        cntNext = IDX_W'(1);
      end else begin
        minNext = SadMax;
        cntNext = '0;
      end
    end else if (countResult) begin
      // Strict compare: ties keep the earlier index, and an all-ones result
      // never displaces the all-ones "empty" value.
      if (SADSum < MinSAD) begin
        minNext = SADSum;
        idxNext = WinCount;
      end
      cntNext = WinCount + IDX_W'(1);  // wraps naturally at 2^IDX_W
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      MinSAD   <= SadMax;
      MinIndex <= '0;
      WinCount <= '0;
    end else begin
      MinSAD   <= minNext;
      MinIndex <= idxNext;
      WinCount <= cntNext;
    end
  end

endmodule

// File: tb/tb_sad2_reduce_min_stage.sv
// -----------------------------------------------------------------------------
// tb_sad2_reduce_min_stage
//
// A table of directed cycles with hand-computed expected outputs comes first.
// Hand sequences for stall, Start-under-stall and reset follow. A randomized
// run is then checked against a reference model. In the model, a result is
// the plain arithmetic sum of the sixteen inputs, delayed by a latency queue.
// The minimum search is tracked with ordinary variables.
// -----------------------------------------------------------------------------
module tb_sad2_reduce_min_stage;

  localparam int TB_IDX_W = 4;   // small so WinCount wraps within the run
  localparam int LAT      = 2;

  logic                Clk = 1'b0;
  logic                Reset;
  logic                InValid;
  logic [31:0]         d [16];
  logic                RegWriteIn;
  logic [4:0]          RegDstIn;
  logic                Stall;
  logic                Start;
  logic                OutValid;
  logic [31:0]         SADSum;
  logic                RegWriteOut;
  logic [4:0]          RegDstOut;
  logic [31:0]         MinSAD;
  logic [TB_IDX_W-1:0] MinIndex;
  logic [TB_IDX_W-1:0] WinCount;

  int total = 0;
  int bad   = 0;

  sad2_reduce_min_stage #(.IDX_W(TB_IDX_W)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid),
    .D0(d[0]),   .D1(d[1]),   .D2(d[2]),   .D3(d[3]),
    .D4(d[4]),   .D5(d[5]),   .D6(d[6]),   .D7(d[7]),
    .D8(d[8]),   .D9(d[9]),   .D10(d[10]), .D11(d[11]),
    .D12(d[12]), .D13(d[13]), .D14(d[14]), .D15(d[15]),
    .RegWriteIn(RegWriteIn), .RegDstIn(RegDstIn), .Stall(Stall), .Start(Start),
    .OutValid(OutValid), .SADSum(SADSum), .RegWriteOut(RegWriteOut),
    .RegDstOut(RegDstOut), .MinSAD(MinSAD), .MinIndex(MinIndex),
    .WinCount(WinCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Data helpers
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {SPREAD, RAMP, SATUR} mode_t;

  task automatic setData(input mode_t mode, input logic [31:0] s);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        RAMP:    d[i] = 32'(i + 1);
        SATUR:   d[i] = 32'hFFFF_FFFF;
        default: d[i] = s / 16 + ((32'(i) < s % 16) ? 32'd1 : 32'd0);
      endcase
    end
  endtask

  task automatic drive(input bit st, input bit iv, input bit sl,
                       input bit rw, input logic [4:0] rd);
    Start = st; InValid = iv; Stall = sl; RegWriteIn = rw; RegDstIn = rd;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit              v;
    longint unsigned sum;
    bit              rw;
    logic [4:0]      rd;
  } res_t;

  res_t            mOut;
  res_t            inflight[$];
  logic [31:0]     mMin;
  int              mIdx;
  int              mCnt;

  function automatic logic [31:0] sat(input longint unsigned s);
    logic [63:0] w;
    w = 64'(s);
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : w[31:0];
  endfunction

  task automatic mdlReset();
    mOut = '{v: 1'b0, sum: 0, rw: 1'b0, rd: 5'd0};
    inflight.delete();
    for (int i = 0; i < LAT - 1; i++) inflight.push_back(mOut);
    mMin = 32'hFFFF_FFFF;
    mIdx = 0;
    mCnt = 0;
  endtask

  task automatic mdlStep();
    bit          counted;
    logic [31:0] r;
    res_t        n;
    counted = mOut.v && !Stall;
    r       = sat(mOut.sum);
    if (Start) begin
      mIdx = 0;
      if (counted) begin mMin = r; mCnt = 1; end
      else begin mMin = 32'hFFFF_FFFF; mCnt = 0; end
    end else if (counted) begin
      if (r < mMin) begin mMin = r; mIdx = mCnt; end
      mCnt = (mCnt + 1) % (1 << TB_IDX_W);
    end
    if (!Stall) begin
      n.v = InValid; n.rw = RegWriteIn; n.rd = RegDstIn; n.sum = 0;
      for (int i = 0; i < 16; i++) n.sum += longint'(d[i]);
      inflight.push_back(n);
      mOut = inflight.pop_front();
    end
  endtask

  // One clock: DUT and model both advance at the edge, outputs read 1 ns later.
  task automatic tick();
    @(posedge Clk);
    if (!Reset) mdlReset();
    else mdlStep();
    #1;
  endtask

  task automatic modelCheck(input string tag);
    check({tag, ".ov"},  OutValid,    mOut.v);
    check({tag, ".rwo"}, RegWriteOut, mOut.v & mOut.rw);
    if (mOut.v) begin
      check({tag, ".sad"}, SADSum,    sat(mOut.sum));
      check({tag, ".rdo"}, RegDstOut, mOut.rd);
    end
    check({tag, ".min"}, MinSAD,   mMin);
    check({tag, ".idx"}, MinIndex, mIdx);
    check({tag, ".cnt"}, WinCount, mCnt);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          st;
    bit          iv;
    mode_t       mode;
    logic [31:0] sum;
    bit          rw;
    logic [4:0]  rd;
    bit          eOv;
    logic [31:0] eSad;
    bit          eRw;
    logic [4:0]  eRd;
    logic [31:0] eMin;
    int          eIdx;
    int          eCnt;
  } vec_t;

  localparam logic [31:0] MX = 32'hFFFF_FFFF;
  vec_t vecs[17];

  initial begin
    // st iv mode    sum rw rd | ov sad rw rd | min idx cnt
    vecs[0]  = '{1, 0, SPREAD, 0,  0, 0,  0, 0,   0, 0,  MX,  0, 0};
    vecs[1]  = '{0, 1, RAMP,   0,  1, 5,  0, 0,   0, 0,  MX,  0, 0};
    vecs[2]  = '{0, 0, SPREAD, 0,  0, 0,  1, 136, 1, 5,  MX,  0, 0};
    vecs[3]  = '{0, 0, SPREAD, 0,  0, 0,  0, 0,   0, 0,  136, 0, 1};
    vecs[4]  = '{1, 1, SPREAD, 50, 1, 3,  0, 0,   0, 0,  MX,  0, 0};
    vecs[5]  = '{0, 1, SPREAD, 20, 0, 4,  1, 50,  1, 3,  MX,  0, 0};
    vecs[6]  = '{0, 1, SPREAD, 20, 1, 6,  1, 20,  0, 4,  50,  0, 1};
    vecs[7]  = '{0, 1, SPREAD, 70, 1, 7,  1, 20,  1, 6,  20,  1, 2};
    vecs[8]  = '{0, 0, SPREAD, 0,  0, 0,  1, 70,  1, 7,  20,  1, 3};
    vecs[9]  = '{0, 0, SPREAD, 0,  0, 0,  0, 0,   0, 0,  20,  1, 4};
    vecs[10] = '{1, 1, SPREAD, 3,  1, 1,  0, 0,   0, 0,  MX,  0, 0};
    vecs[11] = '{0, 1, SPREAD, 9,  1, 2,  1, 3,   1, 1,  MX,  0, 0};
    vecs[12] = '{0, 0, SPREAD, 0,  0, 0,  1, 9,   1, 2,  3,   0, 1};
    vecs[13] = '{1, 0, SPREAD, 0,  0, 0,  0, 0,   0, 0,  9,   0, 1};
    vecs[14] = '{1, 1, SATUR,  0,  1, 9,  0, 0,   0, 0,  MX,  0, 0};
    vecs[15] = '{0, 0, SPREAD, 0,  0, 0,  1, MX,  1, 9,  MX,  0, 0};
    vecs[16] = '{0, 0, SPREAD, 0,  0, 0,  0, 0,   0, 0,  MX,  0, 1};
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    string tag;
    Reset = 1'b0;
    drive(0, 0, 0, 0, 5'd0);
    setData(SPREAD, 0);
    mdlReset();
    repeat (2) @(posedge Clk);
    #1;
    check("rst.ov",  OutValid,    1'b0);
    check("rst.sad", SADSum,      32'd0);
    check("rst.rwo", RegWriteOut, 1'b0);
    check("rst.rdo", RegDstOut,   5'd0);
    check("rst.min", MinSAD,      MX);
    check("rst.idx", MinIndex,    0);
    check("rst.cnt", WinCount,    0);
    @(negedge Clk);
    Reset = 1'b1;

    // Directed table
    for (int i = 0; i < 17; i++) begin
      setData(vecs[i].mode, vecs[i].sum);
      drive(vecs[i].st, vecs[i].iv, 1'b0, vecs[i].rw, vecs[i].rd);
      tick();
      tag = $sformatf("vec%0d", i);
      check({tag, ".ov"},  OutValid,    vecs[i].eOv);
      check({tag, ".rwo"}, RegWriteOut, vecs[i].eRw);
      if (vecs[i].eOv) begin
        check({tag, ".sad"}, SADSum,    vecs[i].eSad);
        check({tag, ".rdo"}, RegDstOut, vecs[i].eRd);
      end
      check({tag, ".min"}, MinSAD,   vecs[i].eMin);
      check({tag, ".idx"}, MinIndex, vecs[i].eIdx);
      check({tag, ".cnt"}, WinCount, vecs[i].eCnt);
    end

    // Stall with a result in stage 1: it emerges 3 cycles late.
    setData(SPREAD, 11);
    drive(1, 1, 0, 1, 5'd12);
    tick();
    modelCheck("stl.load");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 5'd0);
      tick();
      check("stl.frozen.ov", OutValid, 1'b0);
      modelCheck("stl.frozen");
    end
    drive(0, 0, 0, 0, 5'd0);
    tick();
    check("stl.emerge.ov",  OutValid, 1'b1);
    check("stl.emerge.sad", SADSum,   32'd11);
    check("stl.emerge.cnt", WinCount, 0);
    // Stall while OutValid is high: held, and not counted while held.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 5'd0);
      tick();
      check("stl.hold.ov",  OutValid, 1'b1);
      check("stl.hold.cnt", WinCount, 0);
    end
    drive(0, 0, 0, 0, 5'd0);
    tick();
    check("stl.once.ov",  OutValid, 1'b0);
    check("stl.once.cnt", WinCount, 1);
    check("stl.once.min", MinSAD,   32'd11);
    modelCheck("stl.once");

    // Start under Stall resets the search; the pipe does not load.
    setData(SPREAD, 7);
    drive(1, 1, 1, 1, 5'd2);
    tick();
    check("sst.min", MinSAD,   MX);
    check("sst.cnt", WinCount, 0);
    drive(0, 0, 0, 0, 5'd0);
    repeat (2) begin
      tick();
      check("sst.noload.ov", OutValid, 1'b0);
    end
    modelCheck("sst");

    // Reset one cycle after InValid: everything clears at once.
    setData(SPREAD, 5);
    drive(0, 1, 0, 1, 5'd3);
    tick();
    drive(0, 0, 0, 0, 5'd0);
    #2 Reset = 1'b0;
    mdlReset();
    #1;
    check("rmid.ov",  OutValid,    1'b0);
    check("rmid.sad", SADSum,      32'd0);
    check("rmid.rwo", RegWriteOut, 1'b0);
    check("rmid.rdo", RegDstOut,   5'd0);
    check("rmid.min", MinSAD,      MX);
    check("rmid.idx", MinIndex,    0);
    check("rmid.cnt", WinCount,    0);
    repeat (2) tick();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (4) begin
      tick();
      check("rmid.quiet.ov", OutValid, 1'b0);
    end
    setData(SPREAD, 5);
    drive(0, 1, 0, 1, 5'd3);
    tick();
    drive(0, 0, 0, 0, 5'd0);
    tick();
    check("rmid.new.ov",  OutValid, 1'b1);
    check("rmid.new.sad", SADSum,   32'd5);
    modelCheck("rmid.new");

    // Randomized run against the model
    for (int c = 0; c < 600; c++) begin
      int unsigned pick;
      pick = $urandom_range(0, 99);
      for (int i = 0; i < 16; i++) begin
        if (pick < 70)      d[i] = $urandom_range(0, 100);
        else if (pick < 85) d[i] = $urandom;
        else                d[i] = 32'hFFFF_FFFF;
      end
      drive($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 65,
            $urandom_range(0, 99) < 20, 1'($urandom), 5'($urandom));
      tick();
      modelCheck($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
